// File: rtl/keypad_scan_4x4.sv
// 4x4 keypad scanner: one-hot active-low column strobe, 2-flop row sync, frame-based press/release debounce.
// key_valid fires one clk after the frame-end tick of the DEBOUNCE_SCANS-th stable frame; no backpressure, pulse-only output.
module keypad_scan_4x4 #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi_key
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DS_MAX    = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] DS_M1     = CW'(DEBOUNCE_SCANS - 1);

   typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

   logic [3:0]    row_s1, row_s2;
   logic [PW-1:0] presc;
   logic [1:0]    col_idx;
   logic [1:0]    col_nxt;
   logic [15:0]   frame;
   logic          eval;
   logic          tick;

   assign tick    = (presc == PRESC_MAX);
   assign col_nxt = col_idx + 2'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_s1  <= 4'hF;
         row_s2  <= 4'hF;
         presc   <= '0;
         col_idx <= 2'd0;
         col_out <= 4'b1110;
         frame   <= '0;
         eval    <= 1'b0;
      end else begin
         row_s1 <= row_in;
         row_s2 <= row_s1;
         eval   <= 1'b0;
         if (eval)
            frame <= '0;
         // A tick never lands on the eval cycle because SCAN_DIV >= 3.
         if (tick) begin
            presc                        <= '0;
            frame[{col_idx, 2'b00} +: 4] <= ~row_s2;
            col_idx                      <= col_nxt;
            col_out                      <= ~(4'b0001 << col_nxt);
            if (col_idx == 2'd3)
               eval <= 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Frame bit index is col*4+row; key code is row*4+col.
   logic [4:0] n_keys;
   logic [3:0] code;
   logic       is_none, is_single, is_multi;

   always_comb begin
      n_keys = 5'd0;
      code   = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (frame[i]) begin
            n_keys = n_keys + 5'd1;
            code   = 4'((i % 4) * 4 + i / 4);
         end
      end
   end

   assign is_none   = (n_keys == 5'd0);
   assign is_single = (n_keys == 5'd1);
   assign is_multi  = (n_keys > 5'd1);

   state_t        state;
   logic [3:0]    cand;
   logic [CW-1:0] cnt, rcnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cand      <= 4'd0;
         cnt       <= '0;
         rcnt      <= '0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi_key <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (eval) begin
            multi_key <= is_multi;
            case (state)
               IDLE: begin
                  if (is_single) begin
                     cand <= code;
                     cnt  <= CW'(1);
                     if (DEBOUNCE_SCANS == 1) begin
                        key_code  <= code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        cnt       <= DS_MAX;
                        state     <= PRESSED;
                     end else begin
                        state <= DEB_PRESS;
                     end
                  end
               end
               DEB_PRESS: begin
                  if (is_single && code == cand) begin
                     if (cnt >= DS_M1) begin
                        key_code  <= cand;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        cnt       <= DS_MAX;
                        state     <= PRESSED;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else if (is_single) begin
                     cand <= code;
                     cnt  <= CW'(1);
                  end else begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end
               PRESSED: begin
                  if (is_none) begin
                     rcnt <= CW'(1);
                     if (DEBOUNCE_SCANS == 1) begin
                        key_held <= 1'b0;
                        cnt      <= '0;
                        rcnt     <= DS_MAX;
                        state    <= IDLE;
                     end else begin
                        state <= DEB_REL;
                     end
                  end
               end
               DEB_REL: begin
                  if (is_none) begin
                     if (rcnt >= DS_M1) begin
                        key_held <= 1'b0;
                        cnt      <= '0;
                        rcnt     <= DS_MAX;
                        state    <= IDLE;
                     end else begin
                        rcnt <= rcnt + 1'b1;
                     end
                  end else begin
                     rcnt  <= '0;
                     state <= PRESSED;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4 with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-clk frames); a keypad model closes rows
// under the active column, expected presses go into a queue and a monitor checks every key_valid pulse.
module tb_keypad_scan_4x4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid, key_held, multi_key;

   logic [15:0] keys;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [3:0] code;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];

   keypad_scan_4x4 #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .multi_key (multi_key)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // keys bit r*4+c pressed pulls row r low while column c is strobed.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_out[c])
               row_in[r] = 1'b0;
   end

   function automatic logic [15:0] key(input int r, input int c);
      logic [15:0] m;
      m = '0;
      m[r*4+c] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected pulse lands one frame-eval after DEBOUNCE_SCANS frames: 3*16 clks after the key is applied.
   task automatic expect_press(input logic [3:0] code);
      exp_t e;
      e.code = code;
      e.cyc  = cyc + 48;
      exp_q.push_back(e);
   endtask

   // From the negedge just after a frame evaluation, advance n whole frames to the same point.
   task automatic run_frames(input int n);
      repeat (16 * n) @(posedge clk);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (key_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got code %0d at cyc %0d, expected no pulse", key_code, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_code", int'(key_code), int'(e.code));
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_held", int'(key_held), 1);
         end
      end
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: bench did not finish within time budget");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      keys  = '0;
      repeat (3) @(negedge clk);
      chk("rst_col", int'(col_out), 4'b1110);
      chk("rst_code", int'(key_code), 0);
      chk("rst_held", int'(key_held), 0);
      chk("rst_multi", int'(multi_key), 0);
      reset = 1'b1;

      // Scenario 1: free-running column strobe
      for (int j = 1; j <= 16; j++) begin
         @(posedge clk);
         @(negedge clk);
         chk("scan_col", int'(col_out), int'(~(4'b0001 << ((j / 4) % 4)) & 4'hF));
      end
      @(posedge clk);
      @(negedge clk);
      chk("idle_held", int'(key_held), 0);
      chk("idle_multi", int'(multi_key), 0);

      // Scenario 3: one-frame bounce on (0,3), never accepted
      for (int k = 0; k < 5; k++) begin
         keys = key(0, 3);
         run_frames(1);
         chk("bounce_held", int'(key_held), 0);
         keys = '0;
         run_frames(1);
      end

      // Scenario 4: two keys together, then one remains
      keys = key(0, 0) | key(1, 1);
      run_frames(1);
      chk("multi_first", int'(multi_key), 1);
      run_frames(1);
      chk("multi_second", int'(multi_key), 1);
      chk("multi_held", int'(key_held), 0);
      keys = key(0, 0);
      expect_press(4'd0);
      run_frames(1);
      chk("multi_cleared", int'(multi_key), 0);
      run_frames(2);
      chk("single_held", int'(key_held), 1);
      chk("single_code", int'(key_code), 0);
      keys = '0;
      run_frames(3);
      chk("single_released", int'(key_held), 0);

      // Scenario 2: hold (2,1) -> code 9
      keys = key(2, 1);
      expect_press(4'd9);
      run_frames(3);
      chk("k9_held", int'(key_held), 1);
      chk("k9_code", int'(key_code), 9);
      run_frames(1);
      chk("k9_still_held", int'(key_held), 1);

      // Scenario 5: release glitch keeps key_held, then full release
      keys = '0;
      run_frames(1);
      chk("glitch_rel1", int'(key_held), 1);
      keys = key(2, 1);
      run_frames(2);
      chk("glitch_repress", int'(key_held), 1);
      keys = '0;
      run_frames(2);
      chk("rel_two_empty", int'(key_held), 1);
      run_frames(1);
      chk("rel_three_empty", int'(key_held), 0);
      chk("rel_code_kept", int'(key_code), 9);

      // Scenario 6: reset during press debounce on (3,3)
      keys = key(3, 3);
      run_frames(2);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_col", int'(col_out), 4'b1110);
      chk("mid_rst_code", int'(key_code), 0);
      chk("mid_rst_held", int'(key_held), 0);
      chk("mid_rst_multi", int'(multi_key), 0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      expect_press(4'd15);
      run_frames(2);
      chk("post_rst_not_yet", int'(key_held), 0);
      run_frames(1);
      chk("post_rst_held", int'(key_held), 1);
      chk("post_rst_code", int'(key_code), 15);
      run_frames(1);

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
